eye_opening_monitor: RTL and testbench
======================================

Name: eye_opening_monitor

Overview:
- Producer side of the TX-equalization adaptation loop; generates the `opening` / `opening_ready` pair consumed by the parameter-update block.
- Takes signed sampler/ADC values from the RX front end, discards a settling interval after every equaliser parameter change, then measures the inner eye edge over a fixed window.
- Inner eye edge = minimum |sample| over the window. The block reports one opening per window, continuously.

Parameters:
- DATA_W, 8, width of signed input sample (two's complement).
- WINDOW, 256, samples per measurement window; power of two, ≥ 2.
- SETTLE_SAMPLES, 16, valid samples discarded after restart; 0 means no settling.
- OPEN_W, DATA_W-1, width of unsigned opening output.

Ports:
- clock_with_shift  in  1  sampling clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  monitor enable; low forces IDLE.
- restart  in  1  single-cycle pulse; equaliser parameter just changed.
- sample  in  DATA_W  signed sample value.
- sample_valid  in  1  qualifies `sample`.
- opening  out  OPEN_W  min |sample| of the last completed window.
- opening_ready  out  1  single-cycle pulse; `opening` updated this cycle.
- busy  out  1  high in SETTLE or ACCUM.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, opening=0, opening_ready=0, busy=0.
  - Counters cleared; min_reg = 2^(DATA_W-1)-1.
- States: IDLE, SETTLE, ACCUM, REPORT.
- IDLE:
  - Go to SETTLE when enable=1, or go to ACCUM if SETTLE_SAMPLES=0.
  - In either case, settle_cnt and win_cnt are cleared.
- SETTLE:
  - Counts valid samples only; the samples are ignored.
  - After the SETTLE_SAMPLES-th valid sample, go to ACCUM with min_reg=max and win_cnt=0.
- ACCUM, on each valid sample:
  - mag = |sample|. |−2^(DATA_W-1)| saturates to 2^(DATA_W-1)-1.
  - min_reg = min(min_reg, mag); win_cnt++.
  - On the WINDOW-th valid sample, go to REPORT. That sample is included in the minimum.
- REPORT (one cycle):
  - opening <= final minimum; opening_ready=1.
  - min_reg reset to max, win_cnt=0, return to ACCUM. The next window is contiguous, with no settling.
  - A sample_valid arriving in the REPORT cycle counts as sample 1 of the new window.
- Latency: opening_ready asserts exactly 1 cycle after the edge that accepted the last window sample.
- Between pulses, `opening` holds its value; opening_ready=0.
- restart=1 in any non-IDLE state:
  - Go to SETTLE (or ACCUM if SETTLE_SAMPLES=0) with counters cleared.
  - Any partial window is discarded; `opening` is held.
  - restart wins over a simultaneous last-window sample: no opening_ready is produced.
  - restart in IDLE is ignored.
- enable=0 in any state:
  - Go to IDLE next cycle; partial window is discarded; opening is held.
  - enable=0 has priority over restart.
- sample_valid=0 cycles do not advance any counter.
- Counter widths: $clog2(WINDOW)+1 and $clog2(SETTLE_SAMPLES+1). No wrap is possible before the terminal compare.
- busy = (state==SETTLE || state==ACCUM).

Optional Feature:
- Macro EYE_MON_ERRCNT_EN.
- When defined, adds:
  - parameter ERR_THRESH, default 8;
  - output `err_count`, width $clog2(WINDOW)+1.
- `err_count` counts window samples with mag < ERR_THRESH. It updates together with `opening`, in the REPORT cycle, and resets to 0.
- Its internal counter clears on window start, restart and enable low.
- When undefined, neither the port nor the logic exists. Behaviour is otherwise identical.

Decomposition:
- Package eye_mon_pkg holds:
  - the state enum typedef (IDLE/SETTLE/ACCUM/REPORT);
  - the function sat_abs(signed) returning the saturated magnitude;
  - the localparam MAG_MAX.
- One sub-module, eye_min_tracker: clear/valid/mag inputs and a registered min_reg output, with optional below-threshold counter.
- The top level holds the FSM and the counters.

Test Plan:
- Reset, then enable=1, with WINDOW=8, SETTLE_SAMPLES=2. Drive valid samples 100, −100 (settle), then 50, −40, 60, −70, 45, −90, 30, 55.
  - Expect opening_ready 1 cycle after the 8th window sample, with opening=30.
  - The settle samples must not affect the result.
- Window containing −128 only (DATA_W=8) → opening=127. Window containing one sample of 0 → opening=0.
- sample_valid toggling 1/0 every cycle across a full window → exactly one pulse, after 8 valid samples; the idle cycles are not counted.
- restart asserted in the same cycle as the 8th window sample → no opening_ready. The next pulse comes after 2 settle + 8 window samples. Opening holds its prior value meanwhile.
- Two back-to-back windows with minima 20 then 35, with a valid sample in the REPORT cycle → pulses 8 valid samples apart, reporting 20 then 35.
- reset_n dropped mid-ACCUM asynchronously → opening=0, opening_ready=0, busy=0 immediately. With EYE_MON_ERRCNT_EN and ERR_THRESH=8, a window {3,−5,9,12,7,40,8,−2} gives err_count=4.

Source files
------------

// File: rtl/eye_mon_pkg.sv
// Shared state type, magnitude helpers and constants for the eye opening monitor.
package eye_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACCUM  = 2'd2,
        REPORT = 2'd3
    } eye_state_t;

    localparam int unsigned DEFAULT_DATA_W = 8;

    // Largest magnitude representable by a w-bit two's complement sample.
    function automatic logic [31:0] mag_max(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    localparam logic [31:0] MAG_MAX = mag_max(DEFAULT_DATA_W);

    // s is a w-bit sample sign-extended to 32 bits; the most negative code saturates.
    function automatic logic [31:0] sat_abs(input logic [31:0] s, input int unsigned w);
        if (s == ~mag_max(w)) begin
            return mag_max(w);
        end
        if (s[31]) begin
            return -s;
        end
        return s;
    endfunction

endpackage

// File: rtl/eye_min_tracker.sv
// Running minimum of sample magnitudes over a window, with an optional
// below-threshold sample counter enabled by EYE_MON_ERRCNT_EN.
module eye_min_tracker
    import eye_mon_pkg::*;
#(
    parameter int OPEN_W = 7
`ifdef EYE_MON_ERRCNT_EN
    , parameter int ERR_THRESH = 8
    , parameter int CNT_W      = 9
`endif
) (
    input  logic              clock_with_shift,
    input  logic              reset_n,
    input  logic              i_clear,
    input  logic              i_valid,
    input  logic [OPEN_W-1:0] i_mag,
    output logic [OPEN_W-1:0] o_min,
    output logic [OPEN_W-1:0] o_min_next
`ifdef EYE_MON_ERRCNT_EN
    , output logic [CNT_W-1:0] o_err_cnt
    , output logic [CNT_W-1:0] o_err_cnt_next
`endif
);

    localparam logic [OPEN_W-1:0] MIN_INIT = OPEN_W'(mag_max(OPEN_W + 1));

    logic [OPEN_W-1:0] r_min;
    logic [OPEN_W-1:0] w_min_base;

    // A clear together with a valid sample starts the new window with that sample.
    always_comb begin
        w_min_base = i_clear ? MIN_INIT : r_min;
        o_min_next = w_min_base;
        if (i_valid && (i_mag < w_min_base)) begin
            o_min_next = i_mag;
        end
    end

    always_ff @(posedge clock_with_shift or negedge reset_n) begin
        if (!reset_n) begin
            r_min <= MIN_INIT;
        end else begin
            r_min <= o_min_next;
        end
    end

    assign o_min = r_min;

`ifdef EYE_MON_ERRCNT_EN
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] w_err_base;
    logic             w_below;

    assign w_below        = i_valid && (int'(i_mag) < ERR_THRESH);
    assign w_err_base     = i_clear ? '0 : r_err_cnt;
    assign o_err_cnt_next = w_err_base + CNT_W'(w_below);

    always_ff @(posedge clock_with_shift or negedge reset_n) begin
        if (!reset_n) begin
            r_err_cnt <= '0;
        end else begin
            r_err_cnt <= o_err_cnt_next;
        end
    end

    assign o_err_cnt = r_err_cnt;
`endif

endmodule

// File: rtl/eye_opening_monitor.sv
// Eye opening monitor: settles after each equaliser change, then reports the
// minimum |sample| of every WINDOW valid samples. Optional err_count via EYE_MON_ERRCNT_EN.
//
// state  | meaning
// IDLE   | disabled, waiting for enable
// SETTLE | discarding SETTLE_SAMPLES valid samples after (re)start
// ACCUM  | tracking the window minimum
// REPORT | opening_ready high; a valid sample here opens the next window
module eye_opening_monitor
    import eye_mon_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int WINDOW         = 256,
    parameter int SETTLE_SAMPLES = 16,
    parameter int OPEN_W         = DATA_W - 1
`ifdef EYE_MON_ERRCNT_EN
    , parameter int ERR_THRESH   = 8
`endif
) (
    input  logic              clock_with_shift,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              restart,
    input  logic [DATA_W-1:0] sample,
    input  logic              sample_valid,
    output logic [OPEN_W-1:0] opening,
    output logic              opening_ready,
    output logic              busy
`ifdef EYE_MON_ERRCNT_EN
    , output logic [$clog2(WINDOW):0] err_count
`endif
);

    localparam int WCNT_W = $clog2(WINDOW) + 1;
    localparam int SCNT_W = (SETTLE_SAMPLES == 0) ? 1 : $clog2(SETTLE_SAMPLES + 1);
    localparam logic [WCNT_W-1:0] WIN_LAST    = WCNT_W'(WINDOW - 1);
    localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'((SETTLE_SAMPLES == 0) ? 0 : SETTLE_SAMPLES - 1);
    localparam eye_state_t        START_STATE = (SETTLE_SAMPLES == 0) ? ACCUM : SETTLE;

    eye_state_t        r_state;
    logic [SCNT_W-1:0] r_settle_cnt;
    logic [WCNT_W-1:0] r_win_cnt;
    logic [OPEN_W-1:0] r_opening;
    logic              r_ready;
    logic              r_busy;

    logic [31:0]       w_sample_ext;
    logic [31:0]       w_mag_full;
    logic [OPEN_W-1:0] w_mag;
    logic              w_clear;
    logic              w_take;
    logic [OPEN_W-1:0] w_min_reg;
    logic [OPEN_W-1:0] w_min_next;
    logic              w_unused_bits;

    assign w_sample_ext = {{(32 - DATA_W){sample[DATA_W-1]}}, sample};
    assign w_mag_full   = sat_abs(w_sample_ext, DATA_W);
    assign w_mag        = w_mag_full[OPEN_W-1:0];

    // The tracker restarts whenever no window is in progress; REPORT also clears
    // it so a sample arriving there becomes the first of the next window.
    assign w_clear = !enable || restart || (r_state != ACCUM);
    assign w_take  = enable && !restart && sample_valid &&
                     ((r_state == ACCUM) || (r_state == REPORT));

`ifdef EYE_MON_ERRCNT_EN
    logic [WCNT_W-1:0] w_err_reg;
    logic [WCNT_W-1:0] w_err_next;
    logic [WCNT_W-1:0] r_err_count;

    assign w_unused_bits = ^{w_mag_full[31:OPEN_W], w_min_reg, w_err_reg};
`else
    assign w_unused_bits = ^{w_mag_full[31:OPEN_W], w_min_reg};
`endif

    eye_min_tracker #(
        .OPEN_W     (OPEN_W)
`ifdef EYE_MON_ERRCNT_EN
        , .ERR_THRESH (ERR_THRESH)
        , .CNT_W      (WCNT_W)
`endif
    ) u_min_tracker (
        .clock_with_shift (clock_with_shift),
        .reset_n          (reset_n),
        .i_clear          (w_clear),
        .i_valid          (w_take),
        .i_mag            (w_mag),
        .o_min            (w_min_reg),
        .o_min_next       (w_min_next)
`ifdef EYE_MON_ERRCNT_EN
        , .o_err_cnt      (w_err_reg)
        , .o_err_cnt_next (w_err_next)
`endif
    );

    always_ff @(posedge clock_with_shift or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_settle_cnt <= '0;
            r_win_cnt    <= '0;
            r_opening    <= '0;
            r_ready      <= 1'b0;
            r_busy       <= 1'b0;
`ifdef EYE_MON_ERRCNT_EN
            r_err_count  <= '0;
`endif
        end else begin
            r_ready <= 1'b0;
            if (!enable) begin
                r_state      <= IDLE;
                r_busy       <= 1'b0;
                r_settle_cnt <= '0;
                r_win_cnt    <= '0;
            end else if ((r_state == IDLE) || restart) begin
                r_state      <= START_STATE;
                r_busy       <= 1'b1;
                r_settle_cnt <= '0;
                r_win_cnt    <= '0;
            end else begin
                case (r_state)
                    SETTLE: begin
                        if (sample_valid) begin
                            if (r_settle_cnt == SETTLE_LAST) begin
                                r_state      <= ACCUM;
                                r_settle_cnt <= '0;
                                r_win_cnt    <= '0;
                            end else begin
                                r_settle_cnt <= r_settle_cnt + SCNT_W'(1);
                            end
                        end
                    end
                    ACCUM: begin
                        if (sample_valid) begin
                            if (r_win_cnt == WIN_LAST) begin
                                r_state     <= REPORT;
                                r_busy      <= 1'b0;
                                r_win_cnt   <= '0;
                                r_ready     <= 1'b1;
                                r_opening   <= w_min_next;
`ifdef EYE_MON_ERRCNT_EN
                                r_err_count <= w_err_next;
`endif
                            end else begin
                                r_win_cnt <= r_win_cnt + WCNT_W'(1);
                            end
                        end
                    end
                    REPORT: begin
                        r_state   <= ACCUM;
                        r_busy    <= 1'b1;
                        r_win_cnt <= WCNT_W'(sample_valid);
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign opening       = r_opening;
    assign opening_ready = r_ready;
    assign busy          = r_busy;
`ifdef EYE_MON_ERRCNT_EN
    assign err_count     = r_err_count;
`endif

endmodule

// File: tb/tb_eye_opening_monitor.sv
// Directed and randomized bench for eye_opening_monitor against a window-level reference model.
module tb_eye_opening_monitor;

    localparam int DW     = 8;
    localparam int WIN    = 8;
    localparam int SETTLE = 2;
    localparam int OW     = DW - 1;
    localparam int THR    = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          restart;
    logic [DW-1:0] sample;
    logic          sample_valid;
    logic [OW-1:0] opening;
    logic          opening_ready;
    logic          busy;
`ifdef EYE_MON_ERRCNT_EN
    logic [$clog2(WIN):0] err_count;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: windows as queues of magnitudes.
    bit m_active;
    int m_settle_left;
    int m_win[$];
    int m_open;
    bit m_ready;
    int m_err;

    always #5 clk = ~clk;

    eye_opening_monitor #(
        .DATA_W         (DW),
        .WINDOW         (WIN),
        .SETTLE_SAMPLES (SETTLE),
        .OPEN_W         (OW)
`ifdef EYE_MON_ERRCNT_EN
        , .ERR_THRESH   (THR)
`endif
    ) dut (
        .clock_with_shift (clk),
        .reset_n          (reset_n),
        .enable           (enable),
        .restart          (restart),
        .sample           (sample),
        .sample_valid     (sample_valid),
        .opening          (opening),
        .opening_ready    (opening_ready),
        .busy             (busy)
`ifdef EYE_MON_ERRCNT_EN
        , .err_count      (err_count)
`endif
    );

    function automatic int mag_of(input int s);
        if (s == -(2 ** (DW - 1))) return 2 ** (DW - 1) - 1;
        return (s < 0) ? -s : s;
    endfunction

    function automatic void model_reset();
        m_active = 1'b0;
        m_settle_left = 0;
        m_win.delete();
        m_open = 0;
        m_ready = 1'b0;
        m_err = 0;
    endfunction

    function automatic void model_edge(input bit en, input bit rs, input bit vld, input int s);
        int mn;
        int below;
        m_ready = 1'b0;
        if (!en) begin
            m_active = 1'b0;
            m_win.delete();
        end else if (!m_active) begin
            m_active = 1'b1;
            m_settle_left = SETTLE;
            m_win.delete();
        end else if (rs) begin
            m_settle_left = SETTLE;
            m_win.delete();
        end else if (vld) begin
            if (m_settle_left > 0) begin
                m_settle_left--;
            end else begin
                m_win.push_back(mag_of(s));
                if (m_win.size() == WIN) begin
                    mn = 2 ** (DW - 1) - 1;
                    below = 0;
                    foreach (m_win[i]) begin
                        if (m_win[i] < mn) mn = m_win[i];
                        if (m_win[i] < THR) below++;
                    end
                    m_open = mn;
                    m_err = below;
                    m_ready = 1'b1;
                    m_win.delete();
                end
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_outputs(input string phase);
        check({phase, ".opening_ready"}, 32'(opening_ready), 32'(m_ready));
        check({phase, ".opening"}, 32'(opening), 32'(m_open));
        check({phase, ".busy"}, 32'(busy), 32'(m_active && !m_ready));
`ifdef EYE_MON_ERRCNT_EN
        check({phase, ".err_count"}, 32'(err_count), 32'(m_err));
`endif
    endtask

    task automatic step(input string phase, input bit en, input bit rs, input bit vld, input int s);
        enable       = en;
        restart      = rs;
        sample_valid = vld;
        sample       = DW'(s);
        @(posedge clk);
        model_edge(en, rs, vld, s);
        #1;
        check_outputs(phase);
    endtask

    task automatic feed(input string phase, input int vals[$]);
        foreach (vals[i]) step(phase, 1'b1, 1'b0, 1'b1, vals[i]);
    endtask

    initial begin
        int v[$];
        reset_n = 1'b0;
        enable = 1'b0;
        restart = 1'b0;
        sample_valid = 1'b0;
        sample = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        reset_n = 1'b1;

        // Basic window after two settle samples.
        step("start", 1'b1, 1'b0, 1'b0, 0);
        v = '{100, -100, 50, -40, 60, -70, 45, -90, 30, 55};
        feed("basic", v);
        check("basic.final_opening", 32'(opening), 32'd30);
        check("basic.final_ready", 32'(opening_ready), 32'd1);
        step("basic.after", 1'b1, 1'b0, 1'b0, 0);

        // Saturating most-negative code, then a window containing zero.
        v = '{-128, -128, -128, -128, -128, -128, -128, -128};
        feed("sat", v);
        check("sat.final_opening", 32'(opening), 32'd127);
        v = '{90, -80, 0, 70, -60, 50, 40, 33};
        feed("zero", v);
        check("zero.final_opening", 32'(opening), 32'd0);

        // sample_valid toggling: idle cycles do not advance the window.
        for (int i = 0; i < 2 * WIN; i++) begin
            step("toggle", 1'b1, 1'b0, (i % 2) == 0, 11 + i);
        end
        step("toggle.tail", 1'b1, 1'b0, 1'b0, 0);

        // Restart on the last window sample suppresses the report.
        v = '{20, 21, 22, 23, 24, 25, 26};
        feed("rst_mid", v);
        step("rst_last", 1'b1, 1'b1, 1'b1, 5);
        check("rst_last.no_ready", 32'(opening_ready), 32'd0);
        v = '{1, 2, 60, 61, 62, 63, 64, 65, 66, 67};
        feed("rst_after", v);
        check("rst_after.opening", 32'(opening), 32'd60);

        // Back-to-back windows with a sample in the REPORT cycle.
        v = '{40, 20, -30, 50, 60, 70, 80, 90, 35, -36, 37, 38, -39, 40, 41, 42};
        feed("b2b", v);
        check("b2b.second_opening", 32'(opening), 32'd35);

        // Randomized traffic with occasional restart and disable.
        for (int i = 0; i < 600; i++) begin
            step("rand",
                 $urandom_range(59, 0) != 0,
                 $urandom_range(39, 0) == 0,
                 $urandom_range(3, 0) != 0,
                 int'($urandom_range(255, 0)) - 128);
        end

        // Async reset in the middle of a window.
        step("arst.pre", 1'b1, 1'b0, 1'b0, 0);
        step("arst.pre", 1'b0, 1'b0, 1'b0, 0);
        step("arst.pre", 1'b1, 1'b0, 1'b0, 0);
        v = '{7, 8, 9, 10, 11, 12};
        feed("arst.fill", v);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs("arst.now");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_outputs("arst.held");

        // Below-threshold count window.
        step("err.start", 1'b1, 1'b0, 1'b0, 0);
        v = '{100, 100, 3, -5, 9, 12, 7, 40, 8, -2};
        feed("err", v);
        check("err.opening", 32'(opening), 32'd2);
`ifdef EYE_MON_ERRCNT_EN
        check("err.err_count", 32'(err_count), 32'd4);
`endif
        step("err.after", 1'b1, 1'b0, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
